irq_request_latch: RTL and testbench

- Upstream stage of the 8-input priority encoder (p0..p7 in, z4 z2 z1 out).
- Synchronises eight raw interrupt lines and latches them as pending requests.
- Applies a mask and in-service nesting, then drives the encoder inputs.
- Consumes the encoder's 3-bit code on acknowledge, moving the winning request from pending to in-service; end-of-interrupt retires it.

---
 rtl/irq_request_latch.sv | 99 +++++++++
 tb/tb_irq_request_latch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_latch.sv
// Interrupt request latch feeding the 8-input priority encoder: synchronise, latch, mask, nest, ack/eoi.
// Optional IRQ_LEVEL_TRIG_EN: pending follows the synchronised level instead of latching edges.
module irq_request_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    output logic [7:0] req_out,
    output logic       req_any,
    input  logic       ack,
    input  logic [2:0] ack_code,
    input  logic       eoi,
    input  logic [2:0] eoi_code,
    output logic [7:0] in_service,
    output logic       ack_err
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_last;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [7:0] blocked;
    logic [7:0] ack_hot;
    logic [7:0] eoi_hot;
    logic       ack_ok;
    logic [7:0] pending_nxt;
    logic [7:0] in_service_nxt;

`ifndef IRQ_LEVEL_TRIG_EN
    logic [7:0] hist;
    logic [7:0] rise;
`endif

    assign sync_last = sync_q[SYNC_STAGES-1];

    // A source is blocked when any in-service source has equal or higher index.
    always_comb begin
        blocked = '0;
        for (int k = 0; k < 8; k++) begin
            blocked[k] = |(in_service >> k);
        end
    end

    assign req_out = pending & mask & ~blocked;
    assign req_any = |req_out;

    assign ack_hot = 8'b1 << ack_code;
    assign eoi_hot = 8'b1 << eoi_code;
    assign ack_ok  = ack & req_out[ack_code];

    always_comb begin
`ifdef IRQ_LEVEL_TRIG_EN
        pending_nxt = sync_last;
`else
        pending_nxt = (pending & ~(ack_ok ? ack_hot : 8'h00)) | rise;
`endif
        // eoi retires first so an ack of the same code leaves the bit set.
        in_service_nxt = (in_service & ~(eoi ? eoi_hot : 8'h00)) | (ack_ok ? ack_hot : 8'h00);
    end

`ifndef IRQ_LEVEL_TRIG_EN
    assign rise = sync_last & ~hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else begin
            hist <= sync_last;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            pending    <= '0;
            in_service <= '0;
            mask       <= '0;
            ack_err    <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            if (mask_wr) begin
                mask <= mask_data;
            end
            ack_err <= ack & ~req_out[ack_code];
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch; expected values are hand-computed per step.
// Build with IRQ_LEVEL_TRIG_EN to exercise the level-triggered variant instead.
module tb_irq_request_latch;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic [7:0] req_out;
    logic       req_any;
    logic       ack;
    logic [2:0] ack_code;
    logic       eoi;
    logic [2:0] eoi_code;
    logic [7:0] in_service;
    logic       ack_err;

    int n_vec = 0;
    int n_err = 0;

    irq_request_latch #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .req_out    (req_out),
        .req_any    (req_any),
        .ack        (ack),
        .ack_code   (ack_code),
        .eoi        (eoi),
        .eoi_code   (eoi_code),
        .in_service (in_service),
        .ack_err    (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse, then wait until the request is visible on req_out.
    task automatic pulse_irq(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
    endtask

    task automatic do_ack(input logic [2:0] code);
        ack = 1'b1;
        ack_code = code;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi(input logic [2:0] code);
        eoi = 1'b1;
        eoi_code = code;
        tick();
        eoi = 1'b0;
    endtask

    task automatic wr_mask(input logic [7:0] m);
        mask_wr = 1'b1;
        mask_data = m;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = 8'h00; mask_wr = 1'b0; mask_data = 8'h00;
        ack = 1'b0; ack_code = 3'd0; eoi = 1'b0; eoi_code = 3'd0;
        do_reset();
        chk("rst_req_out", req_out, 8'h00);
        chk("rst_req_any", {7'b0, req_any}, 8'h00);
        chk("rst_in_service", in_service, 8'h00);
        chk("rst_ack_err", {7'b0, ack_err}, 8'h00);

`ifdef IRQ_LEVEL_TRIG_EN
        wr_mask(8'hFF);
        irq_in = 8'h02;
        tick(); tick(); tick();
        chk("lvl_req", req_out, 8'h02);
        do_ack(3'd1);
        chk("lvl_ack_is", in_service, 8'h02);
        chk("lvl_ack_req", req_out, 8'h00);
        do_eoi(3'd1);
        chk("lvl_eoi_is", in_service, 8'h00);
        chk("lvl_rereq", req_out, 8'h02);
        irq_in = 8'h00;
        tick(); tick(); tick();
        chk("lvl_drop", req_out, 8'h00);
`else
        wr_mask(8'hFF);
        // Latency: request visible after the third edge, not the second.
        irq_in = 8'h20;
        tick();
        irq_in = 8'h00;
        tick();
        chk("lat_early", req_out, 8'h00);
        tick();
        chk("lat_req", req_out, 8'h20);
        chk("lat_any", {7'b0, req_any}, 8'h01);
        do_ack(3'd5);
        chk("ack5_req", req_out, 8'h00);
        chk("ack5_is", in_service, 8'h20);
        chk("ack5_err", {7'b0, ack_err}, 8'h00);

        // Nesting: 6 preempts, 3 blocked under 5.
        pulse_irq(8'h48);
        chk("nest_req", req_out, 8'h40);
        do_eoi(3'd5);
        chk("nest_eoi_req", req_out, 8'h48);
        chk("nest_eoi_is", in_service, 8'h00);
        do_ack(3'd6);
        chk("ack6_req", req_out, 8'h00);
        do_eoi(3'd6);
        chk("eoi6_req", req_out, 8'h08);
        do_ack(3'd3);
        chk("ack3_is", in_service, 8'h08);
        do_eoi(3'd3);
        do_eoi(3'd3);
        chk("eoi_twice_is", in_service, 8'h00);

        // Masked edge is kept pending until unmasked.
        wr_mask(8'hF7);
        pulse_irq(8'h08);
        chk("masked_req", req_out, 8'h00);
        chk("masked_any", {7'b0, req_any}, 8'h00);
        wr_mask(8'hFF);
        chk("unmask_req", req_out, 8'h08);
        do_ack(3'd3);
        do_eoi(3'd3);

        // Rejected ack.
        pulse_irq(8'h01);
        chk("r0_req", req_out, 8'h01);
        do_ack(3'd2);
        chk("rej_err", {7'b0, ack_err}, 8'h01);
        chk("rej_req", req_out, 8'h01);
        chk("rej_is", in_service, 8'h00);
        tick();
        chk("rej_err_once", {7'b0, ack_err}, 8'h00);

        // Ack with mask write: judged against the old mask.
        mask_wr = 1'b1;
        mask_data = 8'hFE;
        do_ack(3'd0);
        mask_wr = 1'b0;
        chk("ackmask_is", in_service, 8'h01);
        chk("ackmask_err", {7'b0, ack_err}, 8'h00);
        do_eoi(3'd0);
        chk("ackmask_req", req_out, 8'h00);
        wr_mask(8'hFF);
        chk("ackmask_cleared", req_out, 8'h00);

        // New edge on 4 arrives at the detector in the same cycle as ack of 4.
        pulse_irq(8'h10);
        chk("p4_req", req_out, 8'h10);
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        do_ack(3'd4);
        chk("reedge_is", in_service, 8'h10);
        chk("reedge_req", req_out, 8'h00);
        do_eoi(3'd4);
        chk("reedge_repend", req_out, 8'h10);
        do_ack(3'd4);
        do_eoi(3'd4);
        chk("reedge_done", req_out, 8'h00);

        // Reset mid-service discards everything, including the mask.
        pulse_irq(8'h84);
        do_ack(3'd7);
        chk("mid_is", in_service, 8'h80);
        do_reset();
        chk("mid_rst_is", in_service, 8'h00);
        chk("mid_rst_req", req_out, 8'h00);
        pulse_irq(8'h04);
        chk("mid_rst_mask0", req_out, 8'h00);

        // Line held through reset gives exactly one request.
        irq_in = 8'h02;
        do_reset();
        wr_mask(8'hFF);
        tick(); tick();
        chk("held_req", req_out, 8'h02);
        do_ack(3'd1);
        do_eoi(3'd1);
        tick(); tick();
        chk("held_once", req_out, 8'h00);
        irq_in = 8'h00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
